// File: rtl/fp_issue_ctrl_if.sv
// Bundle of command, FP-unit and response signals around fp_issue_ctrl.
// Every valid/ready pair transfers on a rising edge where both are high; a source holds valid and its payload until accepted.
interface fp_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_op_a;
  logic [31:0]      cmd_op_b;
  logic             cmd_mode_fp;
  logic             cmd_round_mode;
  logic [TAG_W-1:0] cmd_tag;

  logic             fu_start;
  logic             fu_ready_out;
  logic [31:0]      fu_op_a;
  logic [31:0]      fu_op_b;
  logic             fu_mode_fp;
  logic             fu_round_mode;
  logic             fu_valid_out;
  logic             fu_ready_in;
  logic [31:0]      fu_result;
  logic [4:0]       fu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  logic [4:0]       sticky_flags;
  logic             flags_clr;
  logic             proto_err;
  logic             idle;

  // Controller side.
  modport master (
    input  cmd_valid, cmd_op_a, cmd_op_b, cmd_mode_fp, cmd_round_mode, cmd_tag,
    output cmd_ready,
    output fu_start, fu_op_a, fu_op_b, fu_mode_fp, fu_round_mode, fu_ready_in,
    input  fu_ready_out, fu_valid_out, fu_result, fu_flags,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag,
    input  rsp_ready,
    output sticky_flags, proto_err, idle,
    input  flags_clr
  );

  // Environment side: command source, FP unit and response consumer.
  modport slave (
    output cmd_valid, cmd_op_a, cmd_op_b, cmd_mode_fp, cmd_round_mode, cmd_tag,
    input  cmd_ready,
    input  fu_start, fu_op_a, fu_op_b, fu_mode_fp, fu_round_mode, fu_ready_in,
    output fu_ready_out, fu_valid_out, fu_result, fu_flags,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag,
    output rsp_ready,
    input  sticky_flags, proto_err, idle,
    output flags_clr
  );
endinterface

// File: rtl/fp_issue_ctrl.sv
// Issues tagged commands to one FP unit, tracks in-flight tags in a FIFO and
// returns in-order tagged results through a 2-entry response buffer.
module fp_issue_ctrl #(
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  fp_issue_ctrl_if.master bus
);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  typedef struct packed {
    logic [31:0]      result;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [CW-1:0]    outstanding;
  logic [TAG_W-1:0] tag_mem [MAX_OUT];
  logic [PW-1:0]    tag_wr_ptr;
  logic [PW-1:0]    tag_rd_ptr;

  rsp_t             rsp_mem [2];
  logic             rsp_wr_ptr;
  logic             rsp_rd_ptr;
  logic [1:0]       rsp_count;

  logic [4:0]       sticky_q;
  logic             proto_q;

  logic             can_issue;
  logic             issue;
  logic             ret;
  logic             ret_valid;
  logic             ret_bad;
  logic             rsp_rd;
  rsp_t             rsp_head;

  // Credit check deliberately ignores a same-cycle retire.
  assign can_issue = bus.fu_ready_out & (outstanding < MAX_CNT);
  assign issue     = bus.cmd_valid & can_issue;
  assign ret       = bus.fu_valid_out & bus.fu_ready_in;
  assign ret_valid = ret & (outstanding != '0);
  assign ret_bad   = ret & (outstanding == '0);
  assign rsp_rd    = bus.rsp_valid & bus.rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rd_ptr];

  assign bus.cmd_ready     = can_issue;
  assign bus.fu_start      = issue;
  assign bus.fu_op_a       = bus.cmd_op_a;
  assign bus.fu_op_b       = bus.cmd_op_b;
  assign bus.fu_mode_fp    = bus.cmd_mode_fp;
  assign bus.fu_round_mode = bus.cmd_round_mode;
  assign bus.fu_ready_in   = (rsp_count < 2'd2);

  assign bus.rsp_valid     = (rsp_count != 2'd0);
  assign bus.rsp_result    = rsp_head.result;
  assign bus.rsp_flags     = rsp_head.flags;
  assign bus.rsp_tag       = rsp_head.tag;
  assign bus.sticky_flags  = sticky_q;
  assign bus.proto_err     = proto_q;
  assign bus.idle          = (outstanding == '0) & (rsp_count == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
    end else begin
      if (issue)     tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (ret_valid) tag_rd_ptr <= tag_rd_ptr + 1'b1;
      case ({issue, ret_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Storage arrays carry no reset; validity lives in the pointers and counts.
  always_ff @(posedge clk) begin
    if (issue)     tag_mem[tag_wr_ptr] <= bus.cmd_tag;
    if (ret_valid) rsp_mem[rsp_wr_ptr] <= '{result: bus.fu_result, flags: bus.fu_flags,
                                            tag: tag_mem[tag_rd_ptr]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wr_ptr <= 1'b0;
      rsp_rd_ptr <= 1'b0;
      rsp_count  <= 2'd0;
    end else begin
      if (ret_valid) rsp_wr_ptr <= ~rsp_wr_ptr;
      if (rsp_rd)    rsp_rd_ptr <= ~rsp_rd_ptr;
      case ({ret_valid, rsp_rd})
        2'b10:   rsp_count <= rsp_count + 2'd1;
        2'b01:   rsp_count <= rsp_count - 2'd1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // A flag arriving in the clear cycle survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      proto_q  <= 1'b0;
    end else begin
      sticky_q <= (bus.flags_clr ? 5'd0 : sticky_q) | (ret_valid ? bus.fu_flags : 5'd0);
      if (ret_bad) proto_q <= 1'b1;
    end
  end
endmodule
